// File: rtl/fw_event_queue.sv
// Firmware event queue: report/warning/error/compare pulses are arbitrated
// by priority into a show-ahead FIFO, and a saturating counter records events that were lost.
module fw_event_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          new_report,
   input  logic          new_warning,
   input  logic          new_error,
   input  logic          new_compare,
   input  logic [31:0]   report_reg,
   input  logic [31:0]   warning_reg,
   input  logic [31:0]   error_reg,
   input  logic [31:0]   expected_reg,
   input  logic [31:0]   measured_reg,
   output logic          evt_valid_o,
   input  logic          evt_ready_i,
   output logic [1:0]    evt_type_o,
   output logic [31:0]   evt_data_o,
   output logic [31:0]   evt_data2_o,
   output logic [AW:0]   count_o,
   output logic [15:0]   drop_count_o
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [1:0]    type_mem  [DEPTH];
   logic [31:0]   data_mem  [DEPTH];
   logic [31:0]   data2_mem [DEPTH];

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [3:0]    pend, pend_nxt;
   logic [3:0]    pulse, cand, sel_oh;
   logic [1:0]    sel_type;
   logic          push, pop;
   logic [31:0]   push_data, push_data2;
   logic [2:0]    drop_inc;
   logic [16:0]   drop_sum;
   logic [15:0]   drop_nxt;

   assign evt_valid_o = (count_o != '0);
   assign pop         = evt_valid_o && evt_ready_i;

   always_comb begin
      pulse      = {new_compare, new_error, new_warning, new_report};
      cand       = pend | pulse;
      sel_type   = 2'd0;
      push_data  = '0;
      push_data2 = '0;
      drop_inc   = '0;
      // priority: error > warning > compare > report
      if (cand[2])      sel_type = 2'd2;
      else if (cand[1]) sel_type = 2'd1;
      else if (cand[3]) sel_type = 2'd3;
      else              sel_type = 2'd0;
      push   = (|cand) && ((count_o != CNT_FULL) || pop);
      sel_oh = push ? (4'b0001 << sel_type) : 4'b0000;
      case (sel_type)
         2'd0: push_data = report_reg;
         2'd1: push_data = warning_reg;
         2'd2: push_data = error_reg;
         default: begin
            push_data  = expected_reg;
            push_data2 = measured_reg;
         end
      endcase
      // a pulse landing on its own pending bit survives only if that bit is pushed now
      for (int t = 0; t < 4; t++) begin
         pend_nxt[t] = sel_oh[t] ? (pend[t] & pulse[t]) : cand[t];
         if (pulse[t] && pend[t] && !sel_oh[t])
            drop_inc = drop_inc + 3'd1;
      end
      drop_sum = {1'b0, drop_count_o} + 17'(drop_inc);
      drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_o      <= '0;
         pend         <= '0;
         drop_count_o <= '0;
      end else begin
         pend         <= pend_nxt;
         drop_count_o <= drop_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_o <= count_o + 1'b1;
            2'b01:   count_o <= count_o - 1'b1;
            default: count_o <= count_o;
         endcase
      end
   end

   // storage needs no reset; outputs are masked while empty
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && push) begin
         type_mem[wr_ptr]  <= sel_type;
         data_mem[wr_ptr]  <= push_data;
         data2_mem[wr_ptr] <= push_data2;
      end
   end

   assign evt_type_o  = evt_valid_o ? type_mem[rd_ptr]  : 2'd0;
   assign evt_data_o  = evt_valid_o ? data_mem[rd_ptr]  : 32'd0;
   assign evt_data2_o = evt_valid_o ? data2_mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fw_event_queue.sv
// Directed bench for fw_event_queue: priority ordering, full/drop behaviour,
// show-ahead outputs and reset during drain.
module tb_fw_event_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        new_report = 1'b0, new_warning = 1'b0, new_error = 1'b0, new_compare = 1'b0;
   logic [31:0] report_reg = '0, warning_reg = '0, error_reg = '0;
   logic [31:0] expected_reg = '0, measured_reg = '0;
   logic        evt_ready = 1'b0;
   logic        evt_valid;
   logic [1:0]  evt_type;
   logic [31:0] evt_data, evt_data2;
   logic [3:0]  count;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

   fw_event_queue #(.DEPTH(8), .AW(3)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .new_report   (new_report),
      .new_warning  (new_warning),
      .new_error    (new_error),
      .new_compare  (new_compare),
      .report_reg   (report_reg),
      .warning_reg  (warning_reg),
      .error_reg    (error_reg),
      .expected_reg (expected_reg),
      .measured_reg (measured_reg),
      .evt_valid_o  (evt_valid),
      .evt_ready_i  (evt_ready),
      .evt_type_o   (evt_type),
      .evt_data_o   (evt_data),
      .evt_data2_o  (evt_data2),
      .count_o      (count),
      .drop_count_o (drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic fill_reports(input int n);
      for (int i = 0; i < n; i++) begin
         report_reg = 32'h100 + i;
         new_report = 1'b1;
         tick();
         new_report = 1'b0;
      end
   endtask

   initial begin
      tick();
      do_reset();
      check_val("rst_count", 32'(count), 32'd0);
      check_val("rst_valid", 32'(evt_valid), 32'd0);
      check_val("rst_drop",  32'(drop_count), 32'd0);
      check_val("rst_type",  32'(evt_type), 32'd0);
      check_val("rst_data",  evt_data, 32'd0);
      check_val("rst_data2", evt_data2, 32'd0);

      // single error with ready held high
      error_reg = 32'hDEAD0001;
      evt_ready = 1'b1;
      new_error = 1'b1;
      tick();
      new_error = 1'b0;
      check_val("single_valid", 32'(evt_valid), 32'd1);
      check_val("single_type",  32'(evt_type), 32'd2);
      check_val("single_data",  evt_data, 32'hDEAD0001);
      check_val("single_data2", evt_data2, 32'd0);
      tick();
      check_val("single_count", 32'(count), 32'd0);
      check_val("single_empty", 32'(evt_valid), 32'd0);

      // ready while empty does nothing
      tick();
      check_val("idle_ready_count", 32'(count), 32'd0);
      evt_ready = 1'b0;

      // compare payload, held stable while stalled
      expected_reg = 32'h12345678;
      measured_reg = 32'h12345679;
      new_compare  = 1'b1;
      tick();
      new_compare = 1'b0;
      check_val("cmp_type",  32'(evt_type), 32'd3);
      check_val("cmp_data",  evt_data, 32'h12345678);
      check_val("cmp_data2", evt_data2, 32'h12345679);
      tick();
      check_val("cmp_stall_data2", evt_data2, 32'h12345679);
      check_val("cmp_stall_count", 32'(count), 32'd1);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check_val("cmp_pop_count", 32'(count), 32'd0);

      // all four pulses together
      report_reg  = 32'hAAAA0000;
      warning_reg = 32'hBBBB0000;
      error_reg   = 32'hCCCC0000;
      {new_report, new_warning, new_error, new_compare} = 4'b1111;
      tick();
      {new_report, new_warning, new_error, new_compare} = 4'b0000;
      check_val("sim_c1", 32'(count), 32'd1);
      check_val("sim_head", 32'(evt_type), 32'd2);
      tick();
      check_val("sim_c2", 32'(count), 32'd2);
      tick();
      check_val("sim_c3", 32'(count), 32'd3);
      tick();
      check_val("sim_c4", 32'(count), 32'd4);
      tick();
      check_val("sim_c4_hold", 32'(count), 32'd4);
      check_val("sim_drop", 32'(drop_count), 32'd0);
      evt_ready = 1'b1;
      check_val("sim_o0_data", evt_data, 32'hCCCC0000);
      tick();
      check_val("sim_o1_type", 32'(evt_type), 32'd1);
      check_val("sim_o1_data", evt_data, 32'hBBBB0000);
      tick();
      check_val("sim_o2_type", 32'(evt_type), 32'd3);
      check_val("sim_o2_data2", evt_data2, 32'h12345679);
      tick();
      check_val("sim_o3_type", 32'(evt_type), 32'd0);
      check_val("sim_o3_data", evt_data, 32'hAAAA0000);
      check_val("sim_o3_data2", evt_data2, 32'd0);
      tick();
      check_val("sim_empty", 32'(count), 32'd0);
      evt_ready = 1'b0;

      // full queue: pending warning enters on the pop cycle
      do_reset();
      fill_reports(8);
      check_val("full_count", 32'(count), 32'd8);
      warning_reg = 32'h0000BEEF;
      new_warning = 1'b1;
      tick();
      new_warning = 1'b0;
      check_val("full_hold_count", 32'(count), 32'd8);
      check_val("full_head", evt_data, 32'h100);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check_val("full_pushpop_count", 32'(count), 32'd8);
      check_val("full_head2", evt_data, 32'h101);
      evt_ready = 1'b1;
      repeat (7) tick();
      check_val("full_tail_type", 32'(evt_type), 32'd1);
      check_val("full_tail_data", evt_data, 32'h0000BEEF);
      check_val("full_tail_count", 32'(count), 32'd1);
      tick();
      check_val("full_drained", 32'(count), 32'd0);
      evt_ready = 1'b0;

      // drop: second warning while first still pending on a full queue
      do_reset();
      fill_reports(8);
      new_warning = 1'b1;
      tick();
      new_warning = 1'b0;
      check_val("drop_none_yet", 32'(drop_count), 32'd0);
      tick();
      tick();
      new_warning = 1'b1;
      tick();
      new_warning = 1'b0;
      check_val("drop_one", 32'(drop_count), 32'd1);
      check_val("drop_count_full", 32'(count), 32'd8);
      // error and report together while full are both pending, no drop
      {new_error, new_report} = 2'b11;
      tick();
      {new_error, new_report} = 2'b00;
      check_val("drop_still_one", 32'(drop_count), 32'd1);
      {new_error, new_report, new_warning} = 3'b111;
      tick();
      {new_error, new_report, new_warning} = 3'b000;
      check_val("drop_four", 32'(drop_count), 32'd4);

      // reset mid-drain, with a pulse during reset
      do_reset();
      fill_reports(5);
      check_val("mid_count5", 32'(count), 32'd5);
      evt_ready = 1'b1;
      rst       = 1'b1;
      new_error = 1'b1;
      tick();
      rst       = 1'b0;
      new_error = 1'b0;
      evt_ready = 1'b0;
      check_val("mid_count", 32'(count), 32'd0);
      check_val("mid_valid", 32'(evt_valid), 32'd0);
      check_val("mid_drop",  32'(drop_count), 32'd0);
      tick();
      check_val("mid_pulse_ignored", 32'(count), 32'd0);
      check_val("mid_data_zero", evt_data, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fw_event_queue.md
FW_EVENT_QUEUE -- requirements
Module: fw_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 wb_clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 wb_rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 new_report  input  1  one-cycle pulse, report_reg written.
REQ-006 new_warning  input  1  one-cycle pulse, warning_reg written.
REQ-007 new_error  input  1  one-cycle pulse, error_reg written.
REQ-008 new_compare  input  1  one-cycle pulse, expected/measured written.
REQ-009 report_reg, warning_reg, error_reg, expected_reg, measured_reg  input  32 each  payload registers, held stable between pulses.
REQ-010 evt_valid_o  output  1  head entry available.
REQ-011 evt_ready_i  input  1  consumer accepts head entry.
REQ-012 evt_type_o  output  2  head type: 0 report, 1 warning, 2 error, 3 compare.
REQ-013 evt_data_o  output  32  head primary payload (expected_reg for compare).
REQ-014 evt_data2_o  output  32  measured_reg for compare; 0 otherwise.
REQ-015 count_o  output  AW+1  entries currently stored, 0..DEPTH.
REQ-016 drop_count_o  output  16  events lost, saturating.

Function
REQ-017 Each pulse SHALL set pending bit pend[type] on the clock edge where it is sampled high.
REQ-018 Each cycle, SHALL select the highest-priority candidate among pend bits OR same-cycle pulses: error > warning > compare > report.
REQ-019 If a candidate exists and (count_o < DEPTH or pop this cycle), SHALL push it and clear its pend bit (or not set it, for a same-cycle pulse); at most one push per cycle.
REQ-020 Payload SHALL be sampled from the input registers in the push cycle.
REQ-021 Non-selected same-cycle pulses SHALL remain pending and be pushed on later cycles in priority order.
REQ-022 A pulse whose pend bit is already set and not being pushed that cycle SHALL be dropped; drop_count_o SHALL increment by the number of such pulses.
REQ-023 drop_count_o SHALL saturate at 16'hFFFF.
REQ-024 Pop SHALL occur iff evt_valid_o && evt_ready_i; head advances on that edge.
REQ-025 evt_valid_o SHALL equal (count_o != 0); evt_type_o/evt_data_o/evt_data2_o SHALL show the head combinationally from storage (show-ahead).
REQ-026 Latency: pulse into empty queue with no pending SHALL give evt_valid_o=1 on the following cycle.
REQ-027 Push and pop in the same cycle SHALL leave count_o unchanged, including when count_o == DEPTH.
REQ-028 Pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH nor underflow.
REQ-029 evt_ready_i while evt_valid_o == 0 SHALL have no effect.
REQ-030 Output fields SHALL remain stable while evt_valid_o && !evt_ready_i.

Reset
REQ-031 wb_rst_i high at a clock edge SHALL clear pointers, count_o=0, pend=0, drop_count_o=0, evt_valid_o=0; storage contents need not be cleared.
REQ-032 Pulses and evt_ready_i sampled during reset SHALL be ignored, including reset asserted mid-drain.
REQ-033 evt_type_o, evt_data_o, evt_data2_o SHALL read 0 while count_o == 0.

Verification
REQ-034 Single: error_reg=32'hDEAD0001, pulse new_error, ready=1 -> next cycle valid=1, type=2, data=32'hDEAD0001, data2=0; popped; count returns 0.
REQ-035 Simultaneous: report, warning, error, compare pulsed same cycle, ready=0 -> entries in order type 2,1,3,0 on consecutive cycles; count_o=4; drop_count_o=0.
REQ-036 Full: DEPTH=8, ready=0, 8 reports pushed, then warning pulse -> pend held, count_o=8; one pop -> warning pushed same cycle, count_o stays 8.
REQ-037 Drop: queue full, two new_warning pulses 3 cycles apart -> drop_count_o=1.
REQ-038 Compare: expected=32'h12345678, measured=32'h12345679 -> head type=3, data=32'h12345678, data2=32'h12345679.
REQ-039 Reset mid-drain: 5 entries queued, wb_rst_i one cycle with ready=1 -> count_o=0, valid=0, drop_count_o=0 next cycle.
